// File: rtl/lcd_timing_pkg.sv
// Shared constants, state encoding and width helper for the LCD timing generator
// and the blocks around it in the display top.
package lcd_timing_pkg;

  localparam int DEF_H_ACTIVE = 32'sd640;
  localparam int DEF_H_FP     = 32'sd16;
  localparam int DEF_H_SYNC   = 32'sd96;
  localparam int DEF_H_BP     = 32'sd48;
  localparam int DEF_V_ACTIVE = 32'sd480;
  localparam int DEF_V_FP     = 32'sd10;
  localparam int DEF_V_SYNC   = 32'sd2;
  localparam int DEF_V_BP     = 32'sd33;
  localparam int DEF_PIPE_DLY = 32'sd3;

  localparam int MODE_DE = 32'sd0;
  localparam int MODE_HV = 32'sd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } lcd_state_e;

  // Counter width able to hold 0..total-1; never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total > 32'sd1) ? $clog2(total) : 32'sd1;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Request/panel bundle between the timing generator (master) and the pixel
// source / panel driver (slave).
interface lcd_timing_gen_if #(
  parameter int H_W = 32'sd10,
  parameter int V_W = 32'sd10
);
  logic           run;
  logic           busy;
  logic           req_active;
  logic [H_W-1:0] req_x;
  logic [V_W-1:0] req_y;
  logic           line_start;
  logic           frame_start;
  logic           lcd_de;
  logic           lcd_hsync;
  logic           lcd_vsync;

  modport master (
    input  run,
    output busy, req_active, req_x, req_y, line_start, frame_start,
           lcd_de, lcd_hsync, lcd_vsync
  );

  modport slave (
    output run,
    input  busy, req_active, req_x, req_y, line_start, frame_start,
           lcd_de, lcd_hsync, lcd_vsync
  );
endinterface

// File: rtl/lcd_delay_line.sv
// Fixed-depth register delay line with synchronous active-low reset and a
// per-bit reset value.
module lcd_delay_line #(
  parameter int               WIDTH   = 32'sd1,
  parameter int               DEPTH   = 32'sd1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_r;

  if (DEPTH == 32'sd1) begin : g_single
    // Single stage register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_r[0] <= RST_VAL;
      end else begin
        stage_r[0] <= din;
      end
    end
  end else begin : g_multi
    // Shift register, stage 0 takes the new sample
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_r <= {DEPTH{RST_VAL}};
      end else begin
        stage_r <= {stage_r[DEPTH-2:0], din};
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/VGA timing generator: zero-latency request strobes for the
// pixel source, and DE/HSYNC/VSYNC delayed to line up with the panel data.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = DEF_PIPE_DLY,
  parameter int HS_POL   = 32'sd0,
  parameter int VS_POL   = 32'sd0,
  parameter int MODE     = MODE_DE
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  lcd_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = cnt_width(H_TOTAL);
  localparam int V_W     = cnt_width(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 32'sd1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] H_ONE    = H_W'(32'sd1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 32'sd1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_ONE    = V_W'(32'sd1);

  localparam logic HS_LVL  = (HS_POL != 32'sd0);
  localparam logic VS_LVL  = (VS_POL != 32'sd0);
  localparam logic HV_MODE = (MODE == MODE_HV);

  if ((PIPE_DLY < 32'sd1) || (H_FP < 32'sd1) || (H_SYNC < 32'sd1) || (H_BP < 32'sd1) ||
      (V_FP < 32'sd1) || (V_SYNC < 32'sd1) || (V_BP < 32'sd1)) begin : g_bad_param
    $error("lcd_timing_gen: PIPE_DLY and all porch/sync widths must be at least 1");
  end

  lcd_state_e     state_r, state_nxt_s;
  logic [H_W-1:0] h_cnt_r, h_nxt_s;
  logic [V_W-1:0] v_cnt_r, v_nxt_s;
  logic           running_s, h_last_s, frame_end_s;
  logic           req_active_s, hs_raw_s, vs_raw_s;
  logic [2:0]     pipe_q_s;

  assign running_s   = (state_r != ST_IDLE);
  assign h_last_s    = (h_cnt_r == H_LAST);
  assign frame_end_s = h_last_s && (v_cnt_r == V_LAST);

  // State and raster counter registers
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      h_cnt_r <= {H_W{1'b0}};
      v_cnt_r <= {V_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
    end
  end

  // Next state and counter advance; a frame in flight always runs to its end
  always_comb begin
    state_nxt_s = state_r;
    h_nxt_s     = h_cnt_r;
    v_nxt_s     = v_cnt_r;
    if (running_s) begin
      if (h_last_s) begin
        h_nxt_s = {H_W{1'b0}};
        if (v_cnt_r == V_LAST) begin
          v_nxt_s = {V_W{1'b0}};
        end else begin
          v_nxt_s = v_cnt_r + V_ONE;
        end
      end else begin
        h_nxt_s = h_cnt_r + H_ONE;
      end
    end else begin
      h_nxt_s = {H_W{1'b0}};
      v_nxt_s = {V_W{1'b0}};
    end
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = bus.run ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (bus.run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = frame_end_s ? ST_IDLE : ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (bus.run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = frame_end_s ? ST_IDLE : ST_STOPPING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign req_active_s = running_s && (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
  assign hs_raw_s     = running_s && (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
  assign vs_raw_s     = running_s && (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);

  assign bus.busy        = running_s;
  assign bus.req_active  = req_active_s;
  assign bus.req_x       = req_active_s ? h_cnt_r : {H_W{1'b0}};
  assign bus.req_y       = req_active_s ? v_cnt_r : {V_W{1'b0}};
  assign bus.line_start  = running_s && (h_cnt_r == {H_W{1'b0}}) && (v_cnt_r < V_ACT);
  assign bus.frame_start = running_s && (h_cnt_r == {H_W{1'b0}}) && (v_cnt_r == {V_W{1'b0}});

  // Raw strobes are kept active-high in the pipe; polarity is applied at the pins
  lcd_delay_line #(
    .WIDTH  (32'sd3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(3'b000)
  ) u_panel_dly (
    .clk  (pixel_clk),
    .rst_n(rst_n),
    .din  ({req_active_s, hs_raw_s, vs_raw_s}),
    .dout (pipe_q_s)
  );

  assign bus.lcd_de    = pipe_q_s[2];
  assign bus.lcd_hsync = (HV_MODE && pipe_q_s[1]) ? HS_LVL : ~HS_LVL;
  assign bus.lcd_vsync = (HV_MODE && pipe_q_s[0]) ? VS_LVL : ~VS_LVL;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a reduced 32x19 raster (16 active px,
// 12 active lines): one HV instance with low syncs, one DE-only with high pols.
module tb_lcd_timing_gen;
  import lcd_timing_pkg::*;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int PD = 3;
  localparam int HT = 32, VT = 19, FRAME = 608;
  localparam int HW = cnt_width(HT);
  localparam int VW = cnt_width(VT);

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  int exp_h = 0, exp_v = 0;
  bit exp_busy = 1'b0;
  bit q_act[3], q_hs[3], q_vs[3];

  lcd_timing_gen_if #(.H_W(HW), .V_W(VW)) bus_hv ();
  lcd_timing_gen_if #(.H_W(HW), .V_W(VW)) bus_de ();

  lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_DLY(PD), .HS_POL(0), .VS_POL(0), .MODE(MODE_HV))
    dut_hv (.pixel_clk(pixel_clk), .rst_n(rst_n), .bus(bus_hv));

  lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_DLY(PD), .HS_POL(1), .VS_POL(1), .MODE(MODE_DE))
    dut_de (.pixel_clk(pixel_clk), .rst_n(rst_n), .bus(bus_de));

  always #5 pixel_clk = ~pixel_clk;

  // Reference raster: visible 0..15 / 0..11, hsync h 20..25, vsync lines 14..15
  function automatic bit m_act();
    return exp_busy && (exp_h < 16) && (exp_v < 12);
  endfunction
  function automatic bit m_hs();
    return exp_busy && (exp_h >= 20) && (exp_h < 26);
  endfunction
  function automatic bit m_vs();
    return exp_busy && (exp_v >= 14) && (exp_v < 16);
  endfunction

  task automatic set_run(input bit r);
    bus_hv.run = r;
    bus_de.run = r;
  endtask

  // One clock: advance the reference raster, then settle 1 ns past the edge
  task automatic tick();
    bit a, h, v, r, rn;
    a = m_act(); h = m_hs(); v = m_vs();
    r = bus_hv.run; rn = rst_n;
    @(posedge pixel_clk);
    #1;
    if (!rn) begin
      exp_busy = 1'b0; exp_h = 0; exp_v = 0;
      for (int i = 0; i < 3; i++) begin q_act[i] = 1'b0; q_hs[i] = 1'b0; q_vs[i] = 1'b0; end
    end else begin
      q_act[2] = q_act[1]; q_act[1] = q_act[0]; q_act[0] = a;
      q_hs[2]  = q_hs[1];  q_hs[1]  = q_hs[0];  q_hs[0]  = h;
      q_vs[2]  = q_vs[1];  q_vs[1]  = q_vs[0];  q_vs[0]  = v;
      if (exp_busy) begin
        if (exp_h == HT - 1) begin
          exp_h = 0;
          if (exp_v == VT - 1) begin exp_v = 0; exp_busy = r; end
          else exp_v = exp_v + 1;
        end else begin
          exp_h = exp_h + 1;
        end
      end else begin
        exp_busy = r;
      end
    end
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    int n;
    n = 0;
    while (!(exp_h == h && exp_v == v) && n < 2 * FRAME) begin tick(); n++; end
    n_checks++;
    if (!(exp_h == h && exp_v == v)) begin
      n_fail++; $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", name, h, v, exp_h, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_run(1'b0);
    tick(); tick();
    n_checks += 11;
    if (bus_hv.busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_hv.busy); end
    if (bus_hv.req_active !== 1'b0)  begin n_fail++; $display("FAIL rst_req_active: got %b want 0", bus_hv.req_active); end
    if (bus_hv.line_start !== 1'b0)  begin n_fail++; $display("FAIL rst_line_start: got %b want 0", bus_hv.line_start); end
    if (bus_hv.frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: got %b want 0", bus_hv.frame_start); end
    if (bus_hv.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL rst_de: got %b want 0", bus_hv.lcd_de); end
    if (bus_hv.lcd_hsync !== 1'b1)   begin n_fail++; $display("FAIL rst_hsync: got %b want 1", bus_hv.lcd_hsync); end
    if (bus_hv.lcd_vsync !== 1'b1)   begin n_fail++; $display("FAIL rst_vsync: got %b want 1", bus_hv.lcd_vsync); end
    if (bus_de.busy !== 1'b0)        begin n_fail++; $display("FAIL rst_de_busy: got %b want 0", bus_de.busy); end
    if (bus_de.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL rst_de_de: got %b want 0", bus_de.lcd_de); end
    if (bus_de.lcd_hsync !== 1'b0)   begin n_fail++; $display("FAIL rst_de_hsync: got %b want 0", bus_de.lcd_hsync); end
    if (bus_de.lcd_vsync !== 1'b0)   begin n_fail++; $display("FAIL rst_de_vsync: got %b want 0", bus_de.lcd_vsync); end
  endtask

  task automatic test_startup();
    rst_n = 1'b1; set_run(1'b1);
    tick();
    n_checks += 7;
    if (bus_hv.busy !== 1'b1)        begin n_fail++; $display("FAIL start_busy: got %b want 1", bus_hv.busy); end
    if (bus_hv.frame_start !== 1'b1) begin n_fail++; $display("FAIL start_frame_start: got %b want 1", bus_hv.frame_start); end
    if (bus_hv.line_start !== 1'b1)  begin n_fail++; $display("FAIL start_line_start: got %b want 1", bus_hv.line_start); end
    if (bus_hv.req_active !== 1'b1)  begin n_fail++; $display("FAIL start_req_active: got %b want 1", bus_hv.req_active); end
    if (bus_hv.req_x !== 5'd0)       begin n_fail++; $display("FAIL start_req_x: got %0d want 0", bus_hv.req_x); end
    if (bus_hv.req_y !== 5'd0)       begin n_fail++; $display("FAIL start_req_y: got %0d want 0", bus_hv.req_y); end
    if (bus_hv.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL start_de_c0: got %b want 0", bus_hv.lcd_de); end
    tick(); tick();
    n_checks += 2;
    if (bus_hv.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL start_de_c2: got %b want 0", bus_hv.lcd_de); end
    if (bus_hv.req_x !== 5'd2)       begin n_fail++; $display("FAIL start_req_x_c2: got %0d want 2", bus_hv.req_x); end
    tick();
    n_checks += 1;
    if (bus_hv.lcd_de !== 1'b1)      begin n_fail++; $display("FAIL start_de_c3: got %b want 1", bus_hv.lcd_de); end
  endtask

  task automatic test_line_timing();
    int act_cnt, hs_cnt, hs_first;
    wait_pos(0, 1, "line_align");
    act_cnt = 0; hs_cnt = 0; hs_first = -1;
    for (int c = 0; c < HT; c++) begin
      n_checks += 6;
      if (bus_hv.req_active !== m_act()) begin n_fail++; $display("FAIL line_req_active h=%0d: got %b want %b", exp_h, bus_hv.req_active, m_act()); end
      if (bus_hv.req_x !== (m_act() ? HW'(exp_h) : 5'd0)) begin n_fail++; $display("FAIL line_req_x h=%0d: got %0d", exp_h, bus_hv.req_x); end
      if (bus_hv.req_y !== (m_act() ? VW'(exp_v) : 5'd0)) begin n_fail++; $display("FAIL line_req_y h=%0d: got %0d", exp_h, bus_hv.req_y); end
      if (bus_hv.line_start !== (exp_h == 0)) begin n_fail++; $display("FAIL line_start h=%0d: got %b", exp_h, bus_hv.line_start); end
      if (bus_hv.lcd_de !== q_act[2]) begin n_fail++; $display("FAIL line_de h=%0d: got %b want %b", exp_h, bus_hv.lcd_de, q_act[2]); end
      if (bus_hv.lcd_hsync !== !q_hs[2]) begin n_fail++; $display("FAIL line_hsync h=%0d: got %b want %b", exp_h, bus_hv.lcd_hsync, !q_hs[2]); end
      if (bus_hv.req_active === 1'b1) act_cnt++;
      if (bus_hv.lcd_hsync === 1'b0) begin hs_cnt++; if (hs_first < 0) hs_first = exp_h; end
      tick();
    end
    n_checks += 3;
    if (act_cnt != 16) begin n_fail++; $display("FAIL line_active_len: got %0d want 16", act_cnt); end
    if (hs_cnt != 6)   begin n_fail++; $display("FAIL line_hsync_len: got %0d want 6", hs_cnt); end
    if (hs_first != 23) begin n_fail++; $display("FAIL line_hsync_start: got h=%0d want 23", hs_first); end
  endtask

  task automatic test_frame_timing();
    int n, act_cnt, vs_cnt;
    n = 0;
    while (bus_hv.frame_start !== 1'b1 && n < 2 * FRAME) begin tick(); n++; end
    n = 0; act_cnt = 0; vs_cnt = 0;
    do begin
      n_checks += 4;
      if (bus_hv.frame_start !== (exp_h == 0 && exp_v == 0)) begin n_fail++; $display("FAIL frame_start (%0d,%0d): got %b", exp_h, exp_v, bus_hv.frame_start); end
      if (bus_hv.req_active !== m_act()) begin n_fail++; $display("FAIL frame_req_active (%0d,%0d): got %b", exp_h, exp_v, bus_hv.req_active); end
      if (bus_hv.lcd_vsync !== !q_vs[2]) begin n_fail++; $display("FAIL frame_vsync (%0d,%0d): got %b", exp_h, exp_v, bus_hv.lcd_vsync); end
      if (bus_hv.lcd_hsync !== !q_hs[2]) begin n_fail++; $display("FAIL frame_hsync (%0d,%0d): got %b", exp_h, exp_v, bus_hv.lcd_hsync); end
      if (bus_hv.req_active === 1'b1) act_cnt++;
      if (bus_hv.lcd_vsync === 1'b0) vs_cnt++;
      tick(); n++;
    end while (bus_hv.frame_start !== 1'b1 && n < 2 * FRAME);
    n_checks += 3;
    if (n != FRAME)     begin n_fail++; $display("FAIL frame_period: got %0d want %0d", n, FRAME); end
    if (act_cnt != 192) begin n_fail++; $display("FAIL frame_active_cnt: got %0d want 192", act_cnt); end
    if (vs_cnt != 64)   begin n_fail++; $display("FAIL frame_vsync_len: got %0d want 64", vs_cnt); end
  endtask

  task automatic test_de_only_mode();
    int rises;
    bit prev;
    wait_pos(0, 0, "de_align");
    rises = 0; prev = bus_de.lcd_de;
    for (int c = 0; c < FRAME; c++) begin
      n_checks += 3;
      if (bus_de.lcd_hsync !== 1'b0) begin n_fail++; $display("FAIL deonly_hsync (%0d,%0d): got %b want 0", exp_h, exp_v, bus_de.lcd_hsync); end
      if (bus_de.lcd_vsync !== 1'b0) begin n_fail++; $display("FAIL deonly_vsync (%0d,%0d): got %b want 0", exp_h, exp_v, bus_de.lcd_vsync); end
      if (bus_de.lcd_de !== q_act[2]) begin n_fail++; $display("FAIL deonly_de (%0d,%0d): got %b want %b", exp_h, exp_v, bus_de.lcd_de, q_act[2]); end
      if (bus_de.lcd_de === 1'b1 && !prev) rises++;
      prev = bus_de.lcd_de;
      tick();
    end
    n_checks += 1;
    if (rises != 12) begin n_fail++; $display("FAIL deonly_de_rises: got %0d want 12", rises); end
  endtask

  task automatic test_stop();
    int n;
    wait_pos(0, 5, "stop_align");
    set_run(1'b0);
    n = 0;
    while (bus_hv.busy === 1'b1 && n < 2 * FRAME) begin
      n_checks += 2;
      if (bus_hv.lcd_de !== q_act[2]) begin n_fail++; $display("FAIL stop_de (%0d,%0d): got %b want %b", exp_h, exp_v, bus_hv.lcd_de, q_act[2]); end
      if (bus_hv.req_active !== m_act()) begin n_fail++; $display("FAIL stop_req_active (%0d,%0d): got %b", exp_h, exp_v, bus_hv.req_active); end
      tick(); n++;
    end
    n_checks += 1;
    if (n != 448) begin n_fail++; $display("FAIL stop_cycles_to_idle: got %0d want 448", n); end
    for (int c = 0; c < 4; c++) begin
      n_checks += 5;
      if (bus_hv.busy !== 1'b0)       begin n_fail++; $display("FAIL stop_idle_busy c=%0d: got %b want 0", c, bus_hv.busy); end
      if (bus_hv.req_active !== 1'b0) begin n_fail++; $display("FAIL stop_idle_req c=%0d: got %b want 0", c, bus_hv.req_active); end
      if (bus_hv.lcd_de !== 1'b0)     begin n_fail++; $display("FAIL stop_idle_de c=%0d: got %b want 0", c, bus_hv.lcd_de); end
      if (bus_hv.lcd_hsync !== 1'b1)  begin n_fail++; $display("FAIL stop_idle_hsync c=%0d: got %b want 1", c, bus_hv.lcd_hsync); end
      if (bus_hv.lcd_vsync !== 1'b1)  begin n_fail++; $display("FAIL stop_idle_vsync c=%0d: got %b want 1", c, bus_hv.lcd_vsync); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    set_run(1'b1);
    tick();
    wait_pos(0, 3, "b2b_drop");
    set_run(1'b0);
    wait_pos(0, 8, "b2b_raise");
    set_run(1'b1);
    wait_pos(31, 18, "b2b_end");
    n_checks += 1;
    if (bus_hv.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 1", bus_hv.busy); end
    tick();
    n_checks += 4;
    if (bus_hv.frame_start !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_start: got %b want 1", bus_hv.frame_start); end
    if (bus_hv.busy !== 1'b1)        begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bus_hv.busy); end
    if (bus_hv.req_x !== 5'd0)       begin n_fail++; $display("FAIL b2b_req_x: got %0d want 0", bus_hv.req_x); end
    if (bus_hv.req_y !== 5'd0)       begin n_fail++; $display("FAIL b2b_req_y: got %0d want 0", bus_hv.req_y); end
  endtask

  task automatic test_mid_line_reset();
    wait_pos(8, 2, "mrst_align");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks += 7;
    if (bus_hv.busy !== 1'b0)        begin n_fail++; $display("FAIL mrst_busy: got %b want 0", bus_hv.busy); end
    if (bus_hv.req_active !== 1'b0)  begin n_fail++; $display("FAIL mrst_req: got %b want 0", bus_hv.req_active); end
    if (bus_hv.frame_start !== 1'b0) begin n_fail++; $display("FAIL mrst_frame_start: got %b want 0", bus_hv.frame_start); end
    if (bus_hv.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL mrst_de: got %b want 0", bus_hv.lcd_de); end
    if (bus_hv.lcd_hsync !== 1'b1)   begin n_fail++; $display("FAIL mrst_hsync: got %b want 1", bus_hv.lcd_hsync); end
    if (bus_hv.lcd_vsync !== 1'b1)   begin n_fail++; $display("FAIL mrst_vsync: got %b want 1", bus_hv.lcd_vsync); end
    if (bus_de.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL mrst_de_de: got %b want 0", bus_de.lcd_de); end
    tick();
    n_checks += 4;
    if (bus_hv.frame_start !== 1'b1) begin n_fail++; $display("FAIL mrst_restart_fs: got %b want 1", bus_hv.frame_start); end
    if (bus_hv.req_x !== 5'd0)       begin n_fail++; $display("FAIL mrst_restart_x: got %0d want 0", bus_hv.req_x); end
    if (bus_hv.req_y !== 5'd0)       begin n_fail++; $display("FAIL mrst_restart_y: got %0d want 0", bus_hv.req_y); end
    if (bus_hv.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL mrst_restart_de0: got %b want 0", bus_hv.lcd_de); end
    tick(); tick();
    n_checks += 1;
    if (bus_hv.lcd_de !== 1'b0)      begin n_fail++; $display("FAIL mrst_restart_de2: got %b want 0", bus_hv.lcd_de); end
    tick();
    n_checks += 1;
    if (bus_hv.lcd_de !== 1'b1)      begin n_fail++; $display("FAIL mrst_restart_de3: got %b want 1", bus_hv.lcd_de); end
  endtask

  initial begin
    set_run(1'b0);
    test_reset();
    test_startup();
    test_line_timing();
    test_frame_timing();
    test_de_only_mode();
    test_stop();
    test_back_to_back();
    test_mid_line_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
